// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity frame controller: FSM states, default
// word width and the bit-counter width helper.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Counter must reach DATA_W-1; one spare bit keeps the compare unambiguous.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/parity_bit_engine.sv
// Bit-serial odd-parity accumulator: starts at 1 on load and toggles on every
// valid one bit, so {word, parity} always carries an odd number of ones.
module parity_bit_engine (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic valid,
  input  logic din,
  output logic parity
);

  // Parity accumulator; load outranks valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b1;
    end else if (load) begin
      parity <= 1'b1;
    end else if (valid && din) begin
      parity <= ~parity;
    end else begin
      parity <= parity;
    end
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Sequencer that captures a word, shifts it LSB-first through the parity engine
// and offers {word, odd parity} downstream. Optional abort input: PARITY_FRAME_ABORT_EN.
module parity_frame_ctrl
  import parity_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PARITY_FRAME_ABORT_EN
  input  logic              abort,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state_r;
  state_t              state_next_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   shift_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                eng_load_s;
  logic                eng_valid_s;
  logic                eng_din_s;
  logic                eng_parity_s;
  logic                abort_s;

`ifdef PARITY_FRAME_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and engine drive decode.
  always_comb begin
    state_next_s = state_r;
    eng_load_s   = 1'b0;
    eng_valid_s  = 1'b0;
    eng_din_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        eng_load_s = 1'b1;
        if (abort_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        eng_valid_s = 1'b1;
        eng_din_s   = shift_r[0];
        if (abort_s) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == LAST_BIT) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (abort_s || out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // Bit counter: cleared in LOAD, advanced once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD:  cnt_r <= {CNT_W{1'b0}};
        ST_SHIFT: cnt_r <= cnt_r + CNT_W'(1);
        default:  cnt_r <= cnt_r;
      endcase
    end
  end

  // Word capture plus a working copy that shifts right to expose bits LSB-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {DATA_W{1'b0}};
      shift_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_IDLE) && in_valid) begin
      data_r  <= in_data;
      shift_r <= in_data;
    end else if (state_r == ST_SHIFT) begin
      data_r  <= data_r;
      shift_r <= shift_r >> 1;
    end else begin
      data_r  <= data_r;
      shift_r <= shift_r;
    end
  end

  parity_bit_engine u_engine (
    .clk    (clk),
    .rst    (rst),
    .load   (eng_load_s),
    .valid  (eng_valid_s),
    .din    (eng_din_s),
    .parity (eng_parity_s)
  );

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_data   = data_r;
  assign out_parity = eng_parity_s;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl (DATA_W=8): directed table, corner
// sequences and randomized words against a ones-count parity model.
module tb_parity_frame_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         abort;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_parity;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks;
  int errors;

  parity_frame_ctrl #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PARITY_FRAME_ABORT_EN
    .abort      (abort),
`endif
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         parity;
  } vec_t;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic model_parity(input logic [W-1:0] w);
    return ($countones(w) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the current point until out_valid (bounded).
  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One full transaction with `hold` cycles of sink back-pressure.
  task automatic run_word(input logic [W-1:0] w, input int hold, input string tag);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_data  = ~w;
    wait_out_valid(n);
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_data"}, int'(out_data), int'(w));
    check({tag, "_parity"}, int'(out_parity), int'(model_parity(w)));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, int'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, int'(out_valid), 0);
    check({tag, "_post_ready"}, int'(in_ready), 1);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int seen;
    logic [W-1:0] w;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    abort     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{8'hB1, 1'b1};
    vecs[1] = '{8'h07, 1'b0};
    vecs[2] = '{8'h00, 1'b1};
    vecs[3] = '{8'hFF, 1'b1};
    vecs[4] = '{8'h80, 1'b0};
    vecs[5] = '{8'h01, 1'b0};

    // Reset
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_parity", int'(out_parity), 1);
    check("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    tick();

    // Table: in_valid and out_ready held high, accept-to-accept every 11 edges
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = vecs[i].data;
      check("tbl_in_ready", int'(in_ready), 1);
      tick();
      check("tbl_busy", int'(busy), 1);
      check("tbl_in_ready_low", int'(in_ready), 0);
      wait_out_valid(n);
      check("tbl_latency", n, 9);
      check("tbl_data", int'(out_data), int'(vecs[i].data));
      check("tbl_parity", int'(out_parity), int'(vecs[i].parity));
      tick();
      check("tbl_ready_after_hs", int'(in_ready), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    // Back-pressure with a competing word held at the input
    in_data  = 8'h07;
    in_valid = 1'b1;
    tick();
    in_data = 8'hAA;
    wait_out_valid(n);
    check("bp_latency", n, 9);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 8'h07);
      check("bp_parity", int'(out_parity), 0);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ready_after_hs", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    wait_out_valid(n);
    check("bp_second_latency", n, 9);
    check("bp_second_data", int'(out_data), 8'hAA);
    check("bp_second_parity", int'(out_parity), int'(model_parity(8'hAA)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Mid-frame reset on the 4th SHIFT cycle of 8'hFF
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mr_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready", int'(in_ready), 1);
    check("mr_out_valid", int'(out_valid), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_out_parity", int'(out_parity), 1);
    check("mr_out_data", int'(out_data), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("mr_no_valid", seen, 0);
    run_word(8'h01, 1, "mr_next");

`ifdef PARITY_FRAME_ABORT_EN
    // Abort during SHIFT
    in_data  = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_in_ready", int'(in_ready), 1);
    check("ab_busy", int'(busy), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("ab_no_valid", seen, 0);
    run_word(8'h01, 0, "ab_next");
    // Abort in DONE beats out_ready
    in_data  = 8'h33;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(n);
    check("abd_latency", n, 9);
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    check("abd_out_valid", int'(out_valid), 0);
    check("abd_in_ready", int'(in_ready), 1);
`endif

    // Randomized words against the ones-count model
    for (int i = 0; i < 24; i++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      run_word(w, int'($urandom_range(0, 3)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
# parity_frame_ctrl

Sequencer for the bit-serial odd-parity generator. Accepts a parallel data word over a valid/ready handshake and pulses `load` into the parity engine. It then shifts the word LSB-first through the engine, one bit per cycle, and presents the word with its odd-parity bit on an output valid/ready handshake. It sits between a parallel word source and the framing/TX stage that needs a parity-protected word.

## Interface
Parameters:
- `DATA_W`, default 8: word width; legal range 2..32.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_W  word to protect; sampled on the accepting edge.
- `in_valid`  in  1  source has a word.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `out_data`  out  DATA_W  captured word, stable while `out_valid`.
- `out_parity`  out  1  odd-parity bit: total ones in {out_data, out_parity} is odd.
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  sink accepts the result.
- `busy`  out  1  high in LOAD, SHIFT and DONE.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `in_ready`=1. If `in_valid`, then on that edge capture `in_data` into the shift register and go to LOAD.
- LOAD (1 cycle): drive engine `load`=1 and `valid`=0. Bit counter cleared to 0. Go to SHIFT.
- SHIFT (DATA_W cycles):
  - Drive engine `valid`=1 and `din`=captured bit[counter], LSB first.
  - Counter increments each edge.
  - On the edge where counter == DATA_W-1, go to DONE.
- DONE: `out_valid`=1, `out_parity`=engine parity, `out_data`=captured word. On `out_valid & out_ready`, go to IDLE.
- Counter width: $clog2(DATA_W)+1. No wrap occurs; counter is only compared while in SHIFT.
- Engine behaviour:
  - Parity register resets to 1 and is set to 1 by `load`.
  - When `valid & din`, parity toggles.
  - `load` has priority over `valid`.
- `in_valid` outside IDLE is ignored; the word is not captured and `in_ready`=0.
- `out_ready` outside DONE is ignored.
- No overlap between words. One word completes per DATA_W+3 cycles minimum: 1 IDLE + 1 LOAD + DATA_W SHIFT + 1 DONE.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `out_parity`=1, counter 0, engine parity 1.
- Let the accepting edge be E0. LOAD occupies the cycle after E0. SHIFT occupies the cycles after E1..E(DATA_W). `out_valid` rises after edge E(DATA_W+1).
- With DATA_W=8, `out_valid` rises 9 edges after acceptance.
- `out_valid` holds, with `out_data` and `out_parity` stable, until the handshake edge. After that edge, `in_ready`=1 in the next cycle.
- `rst` during any state returns everything to reset values on that edge. A partial word is discarded and no `out_valid` is produced.
- If `rst` and an `in_valid` handshake occur on the same edge, reset wins and the word is lost.

## Configuration
- Macro `PARITY_FRAME_ABORT_EN`.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in LOAD, SHIFT or DONE returns to IDLE on that edge. `out_valid` drops and no result is delivered.
  - Engine parity is not cleared; the next LOAD reinitialises it.
  - `abort` has priority over the `out_ready` handshake on the same edge.
  - `abort` in IDLE is ignored, and any simultaneous `in_valid` is still accepted.
- Undefined: no `abort` port; a started frame always runs to DONE.

## Structure
- Shared package `parity_frame_pkg` holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - default `DATA_W` constant;
  - counter-width localparam helper.
- Sub-module `parity_bit_engine`:
  - ports `clk`, `rst`, `load`, `valid`, `din`, `parity`;
  - the bit-serial odd-parity accumulator, driven only by this controller.
- The top level holds the FSM, the counter, the shift/capture register and the handshake logic.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles → `in_ready`=1, `out_valid`=0, `busy`=0, `out_parity`=1.
- Single word: DATA_W=8, `in_data`=8'hB1 (4 ones), `out_ready`=1 → `out_valid` after 9 edges with `out_data`=8'hB1, `out_parity`=1; `in_ready` back high one cycle later.
- Parity values:
  - 8'h07 → `out_parity`=0;
  - 8'h00 → 1;
  - 8'hFF → 1;
  - 8'h80 → 0.
  - Each completes in exactly 11 cycles accept-to-accept with `in_valid` held high.
- Back-pressure: 8'h07 with `out_ready`=0 for 5 cycles → `out_valid`, `out_data`=8'h07 and `out_parity`=0 held stable. `in_ready`=0 throughout; a second `in_valid` word is not accepted until after the handshake.
- Mid-frame reset: assert `rst` on the 4th SHIFT cycle of 8'hFF → all outputs at reset values. A following 8'h01 gives `out_parity`=0, with no corruption from the prior frame.
- With `PARITY_FRAME_ABORT_EN`: `abort` in SHIFT of 8'h0F → IDLE next edge with no `out_valid`. The next word 8'h01 gives `out_parity`=0. `abort` in DONE together with `out_ready`=1 → no transfer counted.
